mdu_issue_ctrl: RTL and testbench

//  Pipeline-side initiator for the multiply/divide unit (MDU). Sits in the E stage.

---
 rtl/mdu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit.
// It drives MDU pulses, tracks a shadow busy count, and flags protocol errors.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_md_op,
  input  logic       e_flush,
  input  logic       d_md_use,
  input  logic       mdu_busy,
  output logic       start,
  output logic [2:0] md_op,
  output logic       mthi,
  output logic       mtlo,
  output logic [1:0] hilo_sel,
  output logic       stall_d,
  output logic [3:0] cnt_q,
  output logic       proto_err
);

  // The shadow counter is 4 bits wide, so both latencies must fit in 1..15.
  if (MULT_LAT == 0 || MULT_LAT > 15 || DIV_LAT == 0 || DIV_LAT > 15) begin : g_lat_range_check
    $error("mdu_issue_ctrl: MULT_LAT and DIV_LAT must be within 1..15");
  end

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
  localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

  logic [3:0] cnt_r;
  logic [3:0] cnt_next_s;
  logic       proto_err_r;
  logic       proto_err_next_s;
  logic       op_arith_s;
  logic       op_mthi_s;
  logic       op_mtlo_s;
  logic       op_mf_s;
  logic [2:0] map_op_s;
  logic [3:0] lat_s;
  logic [1:0] hilo_sel_s;
  logic       busy_s;
  logic       live_s;
  logic       issue_ok_s;
  logic       start_s;
  logic       illegal_s;
  logic       mismatch_s;

  // Decode the E-stage HI/LO op code; codes 9-15 decode as no operation.
  always_comb begin
    op_arith_s = 1'b0;
    op_mthi_s  = 1'b0;
    op_mtlo_s  = 1'b0;
    op_mf_s    = 1'b0;
    map_op_s   = 3'd0;
    lat_s      = 4'd0;
    hilo_sel_s = 2'd0;
    case (e_md_op)
      4'd1: begin op_arith_s = 1'b1; map_op_s = MD_MULT;  lat_s = MULT_LAT_C; end
      4'd2: begin op_arith_s = 1'b1; map_op_s = MD_MULTU; lat_s = MULT_LAT_C; end
      4'd3: begin op_arith_s = 1'b1; map_op_s = MD_DIV;   lat_s = DIV_LAT_C;  end
      4'd4: begin op_arith_s = 1'b1; map_op_s = MD_DIVU;  lat_s = DIV_LAT_C;  end
      4'd5: op_mthi_s = 1'b1;
      4'd6: op_mtlo_s = 1'b1;
      4'd7: begin op_mf_s = 1'b1; hilo_sel_s = 2'd1; end
      4'd8: begin op_mf_s = 1'b1; hilo_sel_s = 2'd2; end
      default: op_arith_s = 1'b0;
    endcase
  end

  // Issue qualification, pulse generation and error detection.
  always_comb begin
    busy_s     = (cnt_r != 4'd0);
    live_s     = e_valid & ~e_flush;
    issue_ok_s = live_s & ~busy_s & ~proto_err_r;
    start_s    = op_arith_s & issue_ok_s;
    // Any HI/LO-class op reaching E while the shadow is busy escaped the D-stage stall.
    illegal_s  = live_s & busy_s & (op_arith_s | op_mthi_s | op_mtlo_s | op_mf_s);
    mismatch_s = (mdu_busy != busy_s);
    if (start_s) begin
      cnt_next_s = lat_s;
    end else if (busy_s) begin
      cnt_next_s = cnt_r - 4'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
    if (illegal_s || mismatch_s) begin
      proto_err_next_s = 1'b1;
    end else begin
      proto_err_next_s = proto_err_r;
    end
  end

  // Shadow occupancy counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= 4'd0;
      proto_err_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      proto_err_r <= proto_err_next_s;
    end
  end

  // Output drive; the stall also covers the start cycle, before mdu_busy rises.
  always_comb begin
    start     = start_s;
    if (start_s) begin
      md_op = map_op_s;
    end else begin
      md_op = 3'd0;
    end
    mthi      = op_mthi_s & issue_ok_s;
    mtlo      = op_mtlo_s & issue_ok_s;
    hilo_sel  = hilo_sel_s;
    stall_d   = d_md_use & (start_s | busy_s);
    cnt_q     = cnt_r;
    proto_err = proto_err_r;
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed self-checking bench for mdu_issue_ctrl, with a small behavioural MDU
// that can be told to drop busy one cycle early.
module tb_mdu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       e_valid;
  logic [3:0] e_md_op;
  logic       e_flush;
  logic       d_md_use;
  logic       mdu_busy;
  logic       start;
  logic [2:0] md_op;
  logic       mthi;
  logic       mtlo;
  logic [1:0] hilo_sel;
  logic       stall_d;
  logic [3:0] cnt_q;
  logic       proto_err;

  int checks;
  int errors;
  int mdu_cnt;
  bit early_drop;

  mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
    .e_flush(e_flush), .d_md_use(d_md_use), .mdu_busy(mdu_busy),
    .start(start), .md_op(md_op), .mthi(mthi), .mtlo(mtlo),
    .hilo_sel(hilo_sel), .stall_d(stall_d), .cnt_q(cnt_q), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU: mult/multu busy 5 cycles, div/divu busy 10 cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) mdu_cnt <= 0;
    else if (start) mdu_cnt <= (md_op == 3'd1 || md_op == 3'd2) ? 5 : 10;
    else if (mdu_cnt > 0) mdu_cnt <= mdu_cnt - 1;
  end
  assign mdu_busy = early_drop ? (mdu_cnt > 1) : (mdu_cnt != 0);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    e_valid = 1'b0; e_md_op = 4'd0; e_flush = 1'b0; d_md_use = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0; early_drop = 1'b0; idle();
    #1;
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_q); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d expected 0", proto_err); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0d expected 0", start); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult_stall();
    int stalls;
    @(negedge clk);
    e_valid = 1'b1; e_md_op = 4'd1; d_md_use = 1'b1;
    #1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL mult_start: got %0d expected 1", start); end
    checks++; if (md_op !== 3'd1) begin errors++; $display("FAIL mult_md_op: got %0d expected 1", md_op); end
    stalls = (stall_d === 1'b1) ? 1 : 0;
    step();
    e_valid = 1'b0; e_md_op = 4'd0;
    for (int i = 5; i >= 1; i--) begin
      #1;
      checks++; if (cnt_q !== 4'(i)) begin errors++; $display("FAIL mult_cnt: got %0d expected %0d", cnt_q, i); end
      if (stall_d === 1'b1) stalls++;
      step();
    end
    #1;
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL mult_cnt_end: got %0d expected 0", cnt_q); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL mult_stall_end: got %0d expected 0", stall_d); end
    checks++; if (stalls != 6) begin errors++; $display("FAIL mult_stall_cycles: got %0d expected 6", stalls); end
    e_valid = 1'b1; e_md_op = 4'd8; d_md_use = 1'b0;
    #1;
    checks++; if (hilo_sel !== 2'd2) begin errors++; $display("FAIL mflo_sel: got %0d expected 2", hilo_sel); end
    step();
    idle();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mult_err: got %0d expected 0", proto_err); end
  endtask

  task automatic test_divu_no_stall();
    @(negedge clk);
    e_valid = 1'b1; e_md_op = 4'd4; d_md_use = 1'b0;
    #1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL divu_start: got %0d expected 1", start); end
    checks++; if (md_op !== 3'd4) begin errors++; $display("FAIL divu_md_op: got %0d expected 4", md_op); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL divu_stall0: got %0d expected 0", stall_d); end
    step();
    e_valid = 1'b0; e_md_op = 4'd0;
    for (int i = 10; i >= 1; i--) begin
      #1;
      checks++; if (cnt_q !== 4'(i)) begin errors++; $display("FAIL divu_cnt: got %0d expected %0d", cnt_q, i); end
      checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL divu_stall: got %0d expected 0", stall_d); end
      step();
    end
    #1;
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL divu_cnt_end: got %0d expected 0", cnt_q); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL divu_err: got %0d expected 0", proto_err); end
  endtask

  task automatic test_flush_and_moves();
    @(negedge clk);
    e_valid = 1'b1; e_md_op = 4'd1; e_flush = 1'b1; d_md_use = 1'b1;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL flush_start: got %0d expected 0", start); end
    checks++; if (md_op !== 3'd0) begin errors++; $display("FAIL flush_md_op: got %0d expected 0", md_op); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0d expected 0", stall_d); end
    step();
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", cnt_q); end
    e_valid = 1'b0; e_flush = 1'b0; d_md_use = 1'b0; e_md_op = 4'd5;
    #1;
    checks++; if (mthi !== 1'b0) begin errors++; $display("FAIL mthi_invalid: got %0d expected 0", mthi); end
    e_valid = 1'b1;
    #1;
    checks++; if (mthi !== 1'b1) begin errors++; $display("FAIL mthi_issue: got %0d expected 1", mthi); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %0d expected 0", start); end
    e_md_op = 4'd6;
    #1;
    checks++; if (mtlo !== 1'b1) begin errors++; $display("FAIL mtlo_issue: got %0d expected 1", mtlo); end
    checks++; if (mthi !== 1'b0) begin errors++; $display("FAIL mtlo_mthi: got %0d expected 0", mthi); end
    e_md_op = 4'd7;
    #1;
    checks++; if (hilo_sel !== 2'd1) begin errors++; $display("FAIL mfhi_sel: got %0d expected 1", hilo_sel); end
    e_md_op = 4'd9;
    #1;
    checks++; if (start !== 1'b0 || hilo_sel !== 2'd0) begin errors++; $display("FAIL op9_none: got start %0d sel %0d expected 0 0", start, hilo_sel); end
    step();
    idle();
    checks++; if (cnt_q !== 4'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL moves_state: got cnt %0d err %0d expected 0 0", cnt_q, proto_err); end
  endtask

  task automatic test_illegal_issue();
    @(negedge clk);
    e_valid = 1'b1; e_md_op = 4'd1;
    step();
    e_valid = 1'b0; e_md_op = 4'd0;
    step();
    step();
    e_valid = 1'b1; e_md_op = 4'd5;
    #1;
    checks++; if (cnt_q !== 4'd3) begin errors++; $display("FAIL illeg_cnt: got %0d expected 3", cnt_q); end
    checks++; if (mthi !== 1'b0) begin errors++; $display("FAIL illeg_mthi: got %0d expected 0", mthi); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL illeg_err_pre: got %0d expected 0", proto_err); end
    step();
    e_valid = 1'b0; e_md_op = 4'd0;
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL illeg_err_set: got %0d expected 1", proto_err); end
    step(); step(); step();
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL illeg_cnt_drain: got %0d expected 0", cnt_q); end
    e_valid = 1'b1; e_md_op = 4'd3; d_md_use = 1'b1;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL err_blocks_start: got %0d expected 0", start); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL err_stall: got %0d expected 0", stall_d); end
    step();
    idle();
    checks++; if (proto_err !== 1'b1 || cnt_q !== 4'd0) begin errors++; $display("FAIL err_sticky: got err %0d cnt %0d expected 1 0", proto_err, cnt_q); end
    pulse_reset();
  endtask

  task automatic test_busy_mismatch();
    @(negedge clk);
    early_drop = 1'b1;
    e_valid = 1'b1; e_md_op = 4'd2;
    step();
    idle();
    for (int i = 5; i >= 1; i--) begin
      #1;
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mism_err_pre: got %0d expected 0 at cnt %0d", proto_err, i); end
      step();
    end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mism_err_set: got %0d expected 1", proto_err); end
    step(); step(); step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mism_err_sticky: got %0d expected 1", proto_err); end
    #2 reset = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mism_err_reset: got %0d expected 0", proto_err); end
    early_drop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    e_valid = 1'b1; e_md_op = 4'd3;
    step();
    idle();
    step(); step(); step();
    #1;
    checks++; if (cnt_q !== 4'd7) begin errors++; $display("FAIL middiv_cnt: got %0d expected 7", cnt_q); end
    #1 reset = 1'b0;
    #1;
    checks++; if (cnt_q !== 4'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL middiv_reset: got cnt %0d err %0d expected 0 0", cnt_q, proto_err); end
    @(negedge clk);
    reset = 1'b1;
    e_valid = 1'b1; e_md_op = 4'd1;
    #1;
    checks++; if (start !== 1'b1 || md_op !== 3'd1) begin errors++; $display("FAIL post_reset_start: got start %0d op %0d expected 1 1", start, md_op); end
    step();
    idle();
    #1;
    checks++; if (cnt_q !== 4'd5) begin errors++; $display("FAIL post_reset_cnt: got %0d expected 5", cnt_q); end
    step(); step(); step(); step(); step();
    checks++; if (cnt_q !== 4'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL post_reset_end: got cnt %0d err %0d expected 0 0", cnt_q, proto_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult_stall();
    test_divu_no_stall();
    test_flush_and_moves();
    test_illegal_issue();
    test_busy_mismatch();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
